// File: rtl/sqrt_iter_param.sv
// Multi-cycle digit-recurrence square root: one root bit per cycle, MSB first,
// with optional fractional bits, remainder output and round-to-nearest.
module sqrt_iter_param #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 0,
    parameter int ROUND = 0,
    localparam int RW   = WIDTH / 2 + FRAC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [WIDTH-1:0] rad,
    output logic [RW-1:0]   root,
    output logic [RW:0]     rem,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [1:0]      state_dbg
);

    // Handshake: start is taken on any edge where ready=1; done is a single
    // cycle pulse qualifying root/rem; abort cancels only while busy=1.

    localparam int XW = 2 * RW;
    localparam int CW = (RW > 1) ? $clog2(RW) : 1;
    localparam logic [CW-1:0] LAST = CW'(RW - 1);

    typedef enum logic [1:0] {IDLE, CALC, RND, DONE} state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q;
    logic [RW:0]   ac_q;
    logic [RW-1:0] q_q;
    logic [CW-1:0] count_q;

    logic [RW+1:0] a, t;
    logic          t_ok;
    logic [RW:0]   ac_n;
    logic [RW-1:0] q_n;
    logic          round_up;
    logic [RW-1:0] root_rnd;

    assign state_dbg = state_q;

    always_comb begin
        a    = {ac_q[RW-1:0], x_q[XW-1 -: 2]};
        t    = a - {q_q, 2'b01};
        t_ok = ~t[RW+1];
        ac_n = t_ok ? t[RW:0] : a[RW:0];
        q_n  = {q_q[RW-2:0], t_ok};
        // ac > q means the true root lies above q + 1/2
        round_up = ({1'b0, q_q} < ac_q);
        root_rnd = (round_up && !(&q_q)) ? q_q + 1'b1 : q_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = start ? CALC : IDLE;
            CALC: begin
                if (abort)
                    state_d = IDLE;
                else if (count_q == LAST)
                    state_d = (ROUND != 0) ? RND : DONE;
            end
            RND:     state_d = abort ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            ac_q    <= '0;
            q_q     <= '0;
            count_q <= '0;
            root    <= '0;
            rem     <= '0;
            busy    <= 1'b0;
            ready   <= 1'b1;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == CALC) || (state_d == RND);
            ready   <= !((state_d == CALC) || (state_d == RND));
            done    <= (state_d == DONE);
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        x_q     <= XW'(rad) << (2 * FRAC);
                        ac_q    <= '0;
                        q_q     <= '0;
                        count_q <= '0;
                    end
                end
                CALC: begin
                    if (!abort) begin
                        ac_q    <= ac_n;
                        q_q     <= q_n;
                        x_q     <= x_q << 2;
                        count_q <= count_q + 1'b1;
                        if (count_q == LAST && ROUND == 0) begin
                            root <= q_n;
                            rem  <= ac_n;
                        end
                    end
                end
                RND: begin
                    if (!abort) begin
                        rem  <= ac_q;
                        root <= root_rnd;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
